projectile_pool: RTL and testbench

//  Parametrised fixed-slot projectile pool: spawns on fire request, moves every active slot each movement tick, retires on screen edge or hit.

---
 rtl/projectile_pool_pkg.sv | 21 ++
 rtl/projectile_pool_if.sv | 31 +++
 rtl/projectile_pool_slot_alloc.sv | 20 ++
 rtl/projectile_pool.sv | 130 +++++++++++++
 tb/tb_projectile_pool.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/projectile_pool_pkg.sv
// rtl/projectile_pool_pkg.sv - shared screen constants, direction encoding and popcount helper for the projectile pool
package projectile_pool_pkg;

    localparam int PP_COORD_W = 10;
    localparam int SCREEN_H   = 480;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    function automatic int popcount32(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/projectile_pool_if.sv
// rtl/projectile_pool_if.sv - fire/spawn/hit inputs and flat coordinate outputs of the projectile pool
interface projectile_pool_if
    import projectile_pool_pkg::*;
#(
    parameter int SLOTS   = 8,
    parameter int COORD_W = PP_COORD_W
);
    localparam int CNT_W = $clog2(SLOTS + 1);

    logic                       fire;
    logic [COORD_W-1:0]         spawn_x;
    logic [COORD_W-1:0]         spawn_y;
    logic [SLOTS-1:0]           hit;
    logic [COORD_W*SLOTS-1:0]   proj_x_flat;
    logic [COORD_W*SLOTS-1:0]   proj_y_flat;
    logic [SLOTS-1:0]           proj_active;
    logic                       fire_accepted;
    logic                       fire_dropped;
    logic [CNT_W-1:0]           active_count;

    modport master (
        output fire, spawn_x, spawn_y, hit,
        input  proj_x_flat, proj_y_flat, proj_active, fire_accepted, fire_dropped, active_count
    );

    modport slave (
        input  fire, spawn_x, spawn_y, hit,
        output proj_x_flat, proj_y_flat, proj_active, fire_accepted, fire_dropped, active_count
    );

endinterface

// File: rtl/projectile_pool_slot_alloc.sv
// rtl/projectile_pool_slot_alloc.sv - lowest-free-slot priority encoder, one-hot grant
module projectile_pool_slot_alloc #(
    parameter int N = 8
) (
    input  logic [N-1:0] busy_i,
    output logic [N-1:0] grant_o,
    output logic         found_o
);

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < N; i++) begin
            if (!busy_i[i] && (grant_o == '0)) begin
                grant_o[i] = 1'b1;
            end
        end
        found_o = |grant_o;
    end

endmodule

// File: rtl/projectile_pool.sv
// rtl/projectile_pool.sv - fixed-slot projectile pool: spawn on fire, move on tick, retire on edge or hit
// Optional: PROJ_AUTOFIRE_EN turns the fire request from rising-edge into level-sensitive autofire.
module projectile_pool
    import projectile_pool_pkg::*;
#(
    parameter int SLOTS          = 8,
    parameter int COORD_W        = PP_COORD_W,
    parameter int TICK_DIV       = 65536,
    parameter int STEP           = 1,
    parameter int DIR_DOWN       = 0,
    parameter int Y_MAX          = SCREEN_H - 1,
    parameter int X_OFFSET       = 12,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             enable,
    projectile_pool_if.slave pif
);

    localparam int   TICK_W  = $clog2(TICK_DIV);
    localparam int   CD_W    = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
    localparam int   CNT_W   = $clog2(SLOTS + 1);
    localparam int   Y_LIMIT = Y_MAX - STEP;
    localparam dir_e DIR     = (DIR_DOWN != 0) ? DIR_DN : DIR_UP;
    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] XOFF_C = COORD_W'(X_OFFSET);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic              prev_fire_q;
    logic              acc_q, drop_q;
    logic              tick, req, accept, found;
    logic [SLOTS-1:0]  active, grant;

    assign tick = enable && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

`ifdef PROJ_AUTOFIRE_EN
    assign req = pif.fire && enable && (cd_q == '0);
`else
    assign req = pif.fire && !prev_fire_q && enable && (cd_q == '0);
`endif

    // Allocation looks only at registered occupancy, so a slot freed this cycle waits a cycle.
    projectile_pool_slot_alloc #(.N(SLOTS)) u_alloc (
        .busy_i  (active),
        .grant_o (grant),
        .found_o (found)
    );

    assign accept = req && found;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        cd_d       = cd_q;
        if (enable) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        end
        if (accept) begin
            cd_d = CD_W'(COOLDOWN_TICKS);
        end else if (tick && (cd_q != '0)) begin
            cd_d = cd_q - CD_W'(1);
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q  <= '0;
            cd_q        <= '0;
            prev_fire_q <= 1'b0;
            acc_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            cd_q        <= cd_d;
            prev_fire_q <= pif.fire;
            acc_q       <= accept;
            drop_q      <= req && !found;
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        logic               act_q, act_d;
        logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

        // Hit beats spawn beats movement; a hit only matters on an occupied slot.
        always_comb begin
            act_d = act_q;
            x_d   = x_q;
            y_d   = y_q;
            if (pif.hit[i] && act_q) begin
                act_d = 1'b0;
            end else if (accept && grant[i]) begin
                act_d = 1'b1;
                x_d   = pif.spawn_x + XOFF_C;
                y_d   = pif.spawn_y;
            end else if (act_q && tick) begin
                if (DIR == DIR_DN) begin
                    if (int'(y_q) > Y_LIMIT) act_d = 1'b0;
                    else                     y_d   = y_q + STEP_C;
                end else begin
                    if (y_q < STEP_C) act_d = 1'b0;
                    else              y_d   = y_q - STEP_C;
                end
            end
        end

        always_ff @(posedge clk25 or negedge rst_n) begin
            if (!rst_n) begin
                act_q <= 1'b0;
                x_q   <= '0;
                y_q   <= '0;
            end else begin
                act_q <= act_d;
                x_q   <= x_d;
                y_q   <= y_d;
            end
        end

        assign active[i]                               = act_q;
        assign pif.proj_x_flat[i*COORD_W +: COORD_W] = x_q;
        assign pif.proj_y_flat[i*COORD_W +: COORD_W] = y_q;
    end

    assign pif.proj_active   = active;
    assign pif.fire_accepted = acc_q;
    assign pif.fire_dropped  = drop_q;
    assign pif.active_count  = CNT_W'(popcount32(32'(active)));

endmodule

// File: tb/tb_projectile_pool.sv
// tb/tb_projectile_pool.sv - randomized bench for projectile_pool: two configurations against a behavioural model
module tb_projectile_pool;

    localparam int SLOTS = 4;
    localparam int CW    = 10;
    localparam int TDIV  = 4;
    localparam int STP   = 2;
    localparam int XOFF  = 12;
    localparam int YMAX  = 479;

    logic             clk25  = 1'b0;
    logic             rst_n  = 1'b1;
    logic             enable = 1'b1;
    logic             fire   = 1'b0;
    logic [CW-1:0]    sx     = '0;
    logic [CW-1:0]    sy     = '0;
    logic [SLOTS-1:0] hit    = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk25 = ~clk25;

    projectile_pool_if #(.SLOTS(SLOTS), .COORD_W(CW)) if0 ();
    projectile_pool_if #(.SLOTS(SLOTS), .COORD_W(CW)) if1 ();

    assign if0.fire = fire;  assign if0.spawn_x = sx;  assign if0.spawn_y = sy;  assign if0.hit = hit;
    assign if1.fire = fire;  assign if1.spawn_x = sx;  assign if1.spawn_y = sy;  assign if1.hit = hit;

    projectile_pool #(.SLOTS(SLOTS), .COORD_W(CW), .TICK_DIV(TDIV), .STEP(STP), .DIR_DOWN(0),
                      .Y_MAX(YMAX), .X_OFFSET(XOFF), .COOLDOWN_TICKS(0))
        dut0 (.clk25(clk25), .rst_n(rst_n), .enable(enable), .pif(if0.slave));

    projectile_pool #(.SLOTS(SLOTS), .COORD_W(CW), .TICK_DIV(TDIV), .STEP(STP), .DIR_DOWN(1),
                      .Y_MAX(YMAX), .X_OFFSET(XOFF), .COOLDOWN_TICKS(3))
        dut1 (.clk25(clk25), .rst_n(rst_n), .enable(enable), .pif(if1.slave));

    logic [SLOTS-1:0]    o_act [2];
    logic [SLOTS*CW-1:0] o_x   [2];
    logic [SLOTS*CW-1:0] o_y   [2];
    logic                o_acc [2];
    logic                o_drop[2];
    logic [2:0]          o_cnt [2];

    assign o_act[0] = if0.proj_active;   assign o_act[1] = if1.proj_active;
    assign o_x[0]   = if0.proj_x_flat;   assign o_x[1]   = if1.proj_x_flat;
    assign o_y[0]   = if0.proj_y_flat;   assign o_y[1]   = if1.proj_y_flat;
    assign o_acc[0] = if0.fire_accepted; assign o_acc[1] = if1.fire_accepted;
    assign o_drop[0]= if0.fire_dropped;  assign o_drop[1]= if1.fire_dropped;
    assign o_cnt[0] = if0.active_count;  assign o_cnt[1] = if1.active_count;

    // Reference state: instance 0 flies up with no cooldown, instance 1 flies down with 3-tick cooldown.
    bit m_act [2][SLOTS];
    int m_x   [2][SLOTS];
    int m_y   [2][SLOTS];
    int m_cd  [2];
    int m_tc  [2];
    bit m_pf  [2];
    bit m_acc [2];
    bit m_drop[2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < SLOTS; s++) begin
                m_act[m][s] = 1'b0; m_x[m][s] = 0; m_y[m][s] = 0;
            end
            m_cd[m] = 0; m_tc[m] = 0; m_pf[m] = 1'b0; m_acc[m] = 1'b0; m_drop[m] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit tk, rq;
            int fr;
            tk = enable && (m_tc[m] == TDIV - 1);
`ifdef PROJ_AUTOFIRE_EN
            rq = fire && enable && (m_cd[m] == 0);
`else
            rq = fire && !m_pf[m] && enable && (m_cd[m] == 0);
`endif
            fr = -1;
            for (int s = SLOTS - 1; s >= 0; s--) if (!m_act[m][s]) fr = s;
            m_acc[m]  = rq && (fr >= 0);
            m_drop[m] = rq && (fr < 0);
            for (int s = 0; s < SLOTS; s++) begin
                if (hit[s] && m_act[m][s]) begin
                    m_act[m][s] = 1'b0;
                end else if (m_acc[m] && s == fr) begin
                    m_act[m][s] = 1'b1;
                    m_x[m][s]   = (int'(sx) + XOFF) % (1 << CW);
                    m_y[m][s]   = int'(sy);
                end else if (m_act[m][s] && tk) begin
                    if (m == 1) begin
                        if (m_y[m][s] + STP > YMAX) m_act[m][s] = 1'b0;
                        else                        m_y[m][s] += STP;
                    end else begin
                        if (m_y[m][s] < STP) m_act[m][s] = 1'b0;
                        else                 m_y[m][s] -= STP;
                    end
                end
            end
            if (m_acc[m])                 m_cd[m] = (m == 0) ? 0 : 3;
            else if (tk && m_cd[m] > 0)   m_cd[m] = m_cd[m] - 1;
            if (enable) m_tc[m] = (m_tc[m] + 1) % TDIV;
            m_pf[m] = fire;
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            logic [SLOTS*CW-1:0] ex, ey;
            logic [SLOTS-1:0]    ea;
            for (int s = 0; s < SLOTS; s++) begin
                ea[s]           = m_act[m][s];
                ex[s*CW +: CW]  = CW'(m_x[m][s]);
                ey[s*CW +: CW]  = CW'(m_y[m][s]);
            end
            check_eq($sformatf("m%0d_active", m), 64'(o_act[m]),  64'(ea));
            check_eq($sformatf("m%0d_x", m),      64'(o_x[m]),    64'(ex));
            check_eq($sformatf("m%0d_y", m),      64'(o_y[m]),    64'(ey));
            check_eq($sformatf("m%0d_acc", m),    64'(o_acc[m]),  64'(m_acc[m]));
            check_eq($sformatf("m%0d_drop", m),   64'(o_drop[m]), 64'(m_drop[m]));
            check_eq($sformatf("m%0d_count", m),  64'(o_cnt[m]),  64'($countones(ea)));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk25);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        check_eq("rst_active", 64'(if0.proj_active),  64'd0);
        check_eq("rst_x",      64'(if0.proj_x_flat),  64'd0);
        check_eq("rst_y",      64'(if0.proj_y_flat),  64'd0);
        check_eq("rst_count",  64'(if0.active_count), 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic fire_edge(input int x, input int y);
        fire = 1'b1; sx = CW'(x); sy = CW'(y);
        step();
        fire = 1'b0;
        step();
    endtask

    initial begin
        #1;
        do_reset();

        // First spawn and its first movement tick.
        fire = 1'b1; sx = 10'd100; sy = 10'd50;
        step();
        check_eq("spawn_acc", 64'(if0.fire_accepted),    64'd1);
        check_eq("spawn_act", 64'(if0.proj_active),      64'd1);
        check_eq("spawn_x",   64'(if0.proj_x_flat[9:0]), 64'd112);
        check_eq("spawn_y",   64'(if0.proj_y_flat[9:0]), 64'd50);
        fire = 1'b0;
        step();
        check_eq("acc_pulse", 64'(if0.fire_accepted),    64'd0);
        step();
        check_eq("pre_tick_y",  64'(if0.proj_y_flat[9:0]), 64'd50);
        step();
        check_eq("post_tick_y", 64'(if0.proj_y_flat[9:0]), 64'd48);

        // Mid-flight reset.
        fire_edge(200, 300);
        fire_edge(300, 300);
        check_eq("pre_rst_count", 64'(if0.active_count), 64'd3);
        do_reset();

        // Fill the pool in index order, fifth request dropped.
        for (int i = 0; i < SLOTS; i++) begin
            fire_edge(10 * i, 300);
            check_eq("fill_order", 64'(if0.proj_active), 64'((1 << (i + 1)) - 1));
        end
        fire = 1'b1;
        step();
        check_eq("full_drop",   64'(if0.fire_dropped), 64'd1);
        check_eq("full_noacc",  64'(if0.fire_accepted), 64'd0);
        check_eq("full_active", 64'(if0.proj_active),  64'hF);
        fire = 1'b0;
        step();

        // Upward edge retire: y=1 with STEP=2 clears and holds y.
        do_reset();
        fire = 1'b1; sx = 10'd5; sy = 10'd1;
        step();
        fire = 1'b0;
        step(); step();
        check_eq("up_pre",  64'(if0.proj_active[0]),   64'd1);
        step();
        check_eq("up_ret",  64'(if0.proj_active[0]),   64'd0);
        check_eq("up_hold", 64'(if0.proj_y_flat[9:0]), 64'd1);

        // Downward edge: 477 -> 479, then retires at the next tick.
        do_reset();
        fire = 1'b1; sy = 10'd477;
        step();
        fire = 1'b0;
        repeat (3) step();
        check_eq("dn_479",  64'(if1.proj_y_flat[9:0]), 64'd479);
        check_eq("dn_live", 64'(if1.proj_active[0]),   64'd1);
        repeat (4) step();
        check_eq("dn_ret",  64'(if1.proj_active[0]),   64'd0);

        // Hit on slot 2 coinciding with a tick and a fire: slot freed but not reused this cycle.
        do_reset();
        for (int i = 0; i < SLOTS; i++) fire_edge(20 * i, 400);
        repeat (3) step();
        hit = 4'b0100; fire = 1'b1;
        step();
        hit = '0; fire = 1'b0;
        check_eq("hit_active", 64'(if0.proj_active),   64'b1011);
        check_eq("hit_drop",   64'(if0.fire_dropped),  64'd1);
        check_eq("hit_noacc",  64'(if0.fire_accepted), 64'd0);
        step();
        fire = 1'b1;
        step();
        fire = 1'b0;
        check_eq("reuse_active", 64'(if0.proj_active),   64'hF);
        check_eq("reuse_acc",    64'(if0.fire_accepted), 64'd1);
        step();

        // Cooldown on instance 1: edge after 2 ticks ignored, after 3 ticks accepted.
        do_reset();
        fire_edge(0, 100);
        repeat (6) step();
        fire = 1'b1;
        step();
        check_eq("cd_block", 64'(if1.fire_accepted), 64'd0);
        fire = 1'b0;
        repeat (4) step();
        fire = 1'b1;
        step();
        check_eq("cd_accept", 64'(if1.fire_accepted), 64'd1);
        fire = 1'b0;
        step();

        // Random traffic including pauses, hits on free slots and occasional resets.
        for (int c = 0; c < 2500; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            fire   = ($urandom_range(0, 2) == 0);
            sx     = CW'($urandom_range(0, 1023));
            sy     = CW'($urandom_range(0, 479));
            hit    = ($urandom_range(0, 3) == 0) ? SLOTS'($urandom) : '0;
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
